// File: rtl/fifo_umbral_if.sv
// fifo_umbral_if: bundle of the request, threshold and status signals of one
// fifo_umbral channel buffer.
//   master modport - producer/consumer side: drives wr_en, data_in, rd_en and
//                    the umbral_alto / umbral_bajo thresholds, observes status.
//   slave modport  - FIFO side: returns data_out, valid_out, count, empty,
//                    full, almost_full, almost_empty and error.
interface fifo_umbral_if #(
    parameter int WIDTH  = 10,
    parameter int ADDR_W = 3
);
    logic              wr_en;
    logic [WIDTH-1:0]  data_in;
    logic              rd_en;
    logic [4:0]        umbral_alto;
    logic [4:0]        umbral_bajo;
    logic [WIDTH-1:0]  data_out;
    logic              valid_out;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              almost_empty;
    logic              error;

    modport master (
        output wr_en, data_in, rd_en, umbral_alto, umbral_bajo,
        input  data_out, valid_out, count, empty, full,
               almost_full, almost_empty, error
    );

    modport slave (
        input  wr_en, data_in, rd_en, umbral_alto, umbral_bajo,
        output data_out, valid_out, count, empty, full,
               almost_full, almost_empty, error
    );
endinterface

// File: rtl/fifo_umbral.sv
// fifo_umbral: synchronous FIFO with programmable almost-full / almost-empty
// thresholds and overflow / underflow error reporting.
//   clk   - single clock, rising edge
//   reset - synchronous, active-high
//   bus   - fifo_umbral_if.slave: wr_en/data_in/rd_en requests, thresholds,
//           registered data_out/valid_out, count and status flags.
// Build option: FIFO_ERROR_STICKY_EN makes error hold until reset; otherwise
// error is a one-cycle pulse after each offending edge.
module fifo_umbral #(
    parameter int WIDTH  = 10,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic          clk,
    input  logic          reset,
    fifo_umbral_if.slave  bus
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    // Wide enough for the 5-bit thresholds and count, both zero-extended.
    localparam int CMP_W = 6;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_r;
    logic [WIDTH-1:0]  data_out_r;
    logic              valid_r;
    logic              error_r;

    logic empty_w;
    logic full_w;
    logic wr_ok;
    logic rd_ok;
    logic overflow;
    logic underflow;

    assign empty_w   = (count_r == '0);
    assign full_w    = (count_r == DEPTH_C);

    // A write into a full FIFO is still legal when a read frees a slot on the
    // same edge; full implies non-empty, so that read is always accepted.
    assign wr_ok     = bus.wr_en && (!full_w || bus.rd_en);
    assign rd_ok     = bus.rd_en && !empty_w;
    assign overflow  = bus.wr_en && full_w && !bus.rd_en;
    assign underflow = bus.rd_en && empty_w;

    // Storage array: not reset, contents are only meaningful behind count.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_r    <= '0;
            data_out_r <= '0;
            valid_r    <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr     <= rd_ptr + ADDR_W'(1);
                data_out_r <= mem[rd_ptr];
            end
            valid_r <= rd_ok;

            if (wr_ok && !rd_ok) begin
                count_r <= count_r + (ADDR_W+1)'(1);
            end else if (rd_ok && !wr_ok) begin
                count_r <= count_r - (ADDR_W+1)'(1);
            end

`ifdef FIFO_ERROR_STICKY_EN
            error_r <= error_r | overflow | underflow;
`else
            error_r <= overflow | underflow;
`endif
        end
    end

    assign bus.data_out     = data_out_r;
    assign bus.valid_out    = valid_r;
    assign bus.count        = count_r;
    assign bus.empty        = empty_w;
    assign bus.full         = full_w;
    // Thresholds follow the live inputs; out-of-range values saturate the
    // flags naturally because count never exceeds DEPTH.
    assign bus.almost_full  = (CMP_W'(count_r) >= CMP_W'(bus.umbral_alto));
    assign bus.almost_empty = (CMP_W'(count_r) <= CMP_W'(bus.umbral_bajo));
    assign bus.error        = error_r;

endmodule
